// File: rtl/uc_gpio_bank.sv
// Memory-mapped GPIO bank: N_PORTS ports with OUT/IN/IRQ_EN/IRQ_PND registers,
// synchronised inputs, rising-edge interrupt capture and registered read-back.
module uc_gpio_bank #(
    parameter int          DATA_W      = 8,
    parameter int          ADDR_W      = 8,
    parameter int          N_PORTS     = 2,
    parameter int unsigned BASE_ADDR   = 8'hF0,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [ADDR_W-1:0]           mem_addr,
    input  logic                        mem_write_en,
    input  logic                        mem_read_en,
    input  logic [DATA_W-1:0]           mem_data,
    output logic [DATA_W-1:0]           rd_data,
    output logic                        rd_valid,
    input  logic [N_PORTS*DATA_W-1:0]   in_gpio,
    output logic [N_PORTS*DATA_W-1:0]   out_gpio,
    output logic                        irq
);

    localparam int NW = N_PORTS * DATA_W;

    localparam logic [ADDR_W:0] WIN_LO = (ADDR_W+1)'(BASE_ADDR);
    localparam logic [ADDR_W:0] WIN_HI =
        (ADDR_W+1)'(BASE_ADDR + 4 * N_PORTS);

    if (N_PORTS < 1 || N_PORTS > 16) begin : g_bad_ports
        $error("uc_gpio_bank: N_PORTS must be 1..16");
    end

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("uc_gpio_bank: SYNC_STAGES must be >= 2");
    end

    if (64'(BASE_ADDR) + 64'(4 * N_PORTS) > (64'd1 << ADDR_W))
    begin : g_bad_window
        $error("uc_gpio_bank: address window exceeds bus range");
    end

    logic [ADDR_W-1:0]              off;
    logic [ADDR_W-3:0]              off_port;
    logic [1:0]                     off_reg;
    logic                           in_win;

    logic [SYNC_STAGES-1:0][NW-1:0] sync_q;
    logic [NW-1:0]                  in_sync;
    logic [NW-1:0]                  prev_q;
    logic [NW-1:0]                  rise;

    logic [NW-1:0]                  out_q;
    logic [NW-1:0]                  en_q;
    logic [NW-1:0]                  pnd_q;
    logic [NW-1:0]                  pnd_clr;

    logic [N_PORTS-1:0]             wr_out;
    logic [N_PORTS-1:0]             wr_en;
    logic [DATA_W-1:0]              rd_mux;

    assign off      = mem_addr - ADDR_W'(BASE_ADDR);
    assign off_port = off[ADDR_W-1:2];
    assign off_reg  = off[1:0];
    assign in_win   = ({1'b0, mem_addr} >= WIN_LO) &&
                      ({1'b0, mem_addr} <  WIN_HI);

    assign in_sync  = sync_q[SYNC_STAGES-1];
    assign rise     = in_sync & ~prev_q & en_q;

    // Read mux always sees pre-write state, so read-during-write is old data.
    always_comb begin
        wr_out  = '0;
        wr_en   = '0;
        pnd_clr = '0;
        rd_mux  = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            if (in_win && off_port == (ADDR_W-2)'(p)) begin
                unique case (off_reg)
                    2'd0: begin
                        wr_out[p] = mem_write_en;
                        rd_mux    = out_q[p*DATA_W +: DATA_W];
                    end
                    2'd1: begin
                        rd_mux    = in_sync[p*DATA_W +: DATA_W];
                    end
                    2'd2: begin
                        wr_en[p]  = mem_write_en;
                        rd_mux    = en_q[p*DATA_W +: DATA_W];
                    end
                    default: begin
                        if (mem_write_en)
                            pnd_clr[p*DATA_W +: DATA_W] = mem_data;
                        rd_mux    = pnd_q[p*DATA_W +: DATA_W];
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_gpio};
            prev_q <= in_sync;
        end
    end

    // A new edge outranks a same-cycle W1C so no interrupt is ever dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
            en_q  <= '0;
            pnd_q <= '0;
        end else begin
            pnd_q <= (pnd_q & ~pnd_clr) | rise;
            for (int p = 0; p < N_PORTS; p++) begin
                if (wr_out[p])
                    out_q[p*DATA_W +: DATA_W] <= mem_data;
                if (wr_en[p])
                    en_q[p*DATA_W +: DATA_W] <= mem_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= mem_read_en;
            if (mem_read_en)
                rd_data <= rd_mux;
        end
    end

    assign out_gpio = out_q;
    assign irq      = |pnd_q;

endmodule

// File: tb/tb_uc_gpio_bank.sv
// Bench for uc_gpio_bank: directed scenarios plus random traffic, checked
// every cycle against a register-map level reference model.
module tb_uc_gpio_bank;

    localparam int          DW   = 8;
    localparam int          AW   = 8;
    localparam int          NP   = 2;
    localparam int          SS   = 2;
    localparam int unsigned BASE = 32'hF0;
    localparam int          NW   = NP * DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          we;
    logic          re;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic [NW-1:0] gin;
    logic [NW-1:0] out_gpio;
    logic          irq;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uc_gpio_bank #(
        .DATA_W(DW), .ADDR_W(AW), .N_PORTS(NP),
        .BASE_ADDR(BASE), .SYNC_STAGES(SS)
    ) dut (
        .clk(clk), .rst(rst),
        .mem_addr(addr), .mem_write_en(we), .mem_read_en(re),
        .mem_data(wdata), .rd_data(rd_data), .rd_valid(rd_valid),
        .in_gpio(gin), .out_gpio(out_gpio), .irq(irq)
    );

    // Reference model: register contents per port plus a delay line of
    // in_gpio samples taken at each edge (hist[0] = newest).
    logic [DW-1:0] m_out [NP];
    logic [DW-1:0] m_en  [NP];
    logic [DW-1:0] m_pnd [NP];
    logic [DW-1:0] m_rise[NP];
    logic [NW-1:0] hist  [SS+1];
    logic [DW-1:0] m_rd  = '0;
    logic          m_rv  = 1'b0;
    bit            m_live = 1'b0;
    logic [NW-1:0] exp_out;

    function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
        int o;
        int p;
        o = int'(a) - int'(BASE);
        if (o < 0 || o >= 4 * NP) return '0;
        p = o / 4;
        case (o % 4)
            0:       return m_out[p];
            1:       return hist[SS-1][p*DW +: DW];
            2:       return m_en[p];
            default: return m_pnd[p];
        endcase
    endfunction

    always @(posedge clk) begin
        int o;
        int p;
        if (rst) begin
            for (int i = 0; i < NP; i++) begin
                m_out[i] = '0;
                m_en[i]  = '0;
                m_pnd[i] = '0;
            end
            for (int i = 0; i <= SS; i++) hist[i] = '0;
            m_rd   = '0;
            m_rv   = 1'b0;
            m_live = 1'b1;
        end else begin
            m_rv = re;
            if (re) m_rd = m_read(addr);
            for (int i = 0; i < NP; i++)
                m_rise[i] = hist[SS-1][i*DW +: DW] &
                            ~hist[SS][i*DW +: DW] & m_en[i];
            o = int'(addr) - int'(BASE);
            if (we && o >= 0 && o < 4 * NP) begin
                p = o / 4;
                case (o % 4)
                    0:       m_out[p] = wdata;
                    2:       m_en[p]  = wdata;
                    3:       m_pnd[p] = m_pnd[p] & ~wdata;
                    default: ;
                endcase
            end
            for (int i = 0; i < NP; i++) m_pnd[i] = m_pnd[i] | m_rise[i];
            for (int i = SS; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = gin;
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_live) begin
            logic any;
            any = 1'b0;
            for (int i = 0; i < NP; i++) begin
                exp_out[i*DW +: DW] = m_out[i];
                any = any | (|m_pnd[i]);
            end
            chk("out_gpio", 32'(out_gpio), 32'(exp_out));
            chk("irq",      32'(irq),      32'(any));
            chk("rd_valid", 32'(rd_valid), 32'(m_rv));
            chk("rd_data",  32'(rd_data),  32'(m_rd));
        end
    end

    task automatic cyc(input logic r, input logic w, input logic rd,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
        rst   = r;
        we    = w;
        re    = rd;
        addr  = a;
        wdata = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        cyc(1'b0, 1'b1, 1'b0, a, d);
    endtask

    task automatic rd(input logic [AW-1:0] a);
        cyc(1'b0, 1'b0, 1'b1, a, '0);
    endtask

    initial begin
        rst   = 1'b1;
        we    = 1'b0;
        re    = 1'b0;
        addr  = '0;
        wdata = '0;
        gin   = '1;

        // reset with inputs high, then IN readback
        cyc(1'b1, 1'b0, 1'b0, '0, '0);
        cyc(1'b1, 1'b0, 1'b0, '0, '0);
        chk("rst_out",   32'(out_gpio), 32'h0);
        chk("rst_irq",   32'(irq),      32'h0);
        chk("rst_rv",    32'(rd_valid), 32'h0);
        idle(SS + 1);
        rd(8'hF1);
        chk("in0_data",  32'(rd_data),  32'hFF);
        chk("in0_valid", 32'(rd_valid), 32'h1);
        rd(8'hF5);
        chk("in1_data",  32'(rd_data),  32'hFF);

        // port1 OUT write and readback
        wr(8'hF4, 8'hA5);
        chk("out1_wr",   32'(out_gpio), 32'hA500);
        rd(8'hF4);
        chk("out1_rd",   32'(rd_data),  32'hA5);
        chk("out1_rv",   32'(rd_valid), 32'h1);
        idle(1);
        chk("rv_pulse",  32'(rd_valid), 32'h0);
        chk("rd_hold",   32'(rd_data),  32'hA5);

        // rising edge capture latency and W1C clear
        gin = '0;
        idle(4);
        chk("fall_noirq", 32'(irq), 32'h0);
        wr(8'hF2, 8'h01);
        gin = 16'h0001;
        idle(1);
        chk("edge_k",    32'(irq), 32'h0);
        idle(1);
        chk("edge_k1",   32'(irq), 32'h0);
        idle(1);
        chk("edge_k2",   32'(irq), 32'h1);
        rd(8'hF3);
        chk("pnd0_rd",   32'(rd_data), 32'h01);
        wr(8'hF3, 8'h01);
        chk("w1c_clr",   32'(irq), 32'h0);

        // W1C on the same edge a new rise lands: set wins
        gin = '0;
        idle(4);
        gin = 16'h0001;
        idle(2);
        wr(8'hF3, 8'h01);
        chk("set_wins",  32'(irq), 32'h1);
        rd(8'hF3);
        chk("set_pnd",   32'(rd_data), 32'h01);
        wr(8'hF3, 8'h01);
        chk("clr_again", 32'(irq), 32'h0);

        // out-of-window access and read-during-write
        rd(8'hEF);
        chk("oow_data",  32'(rd_data),  32'h0);
        chk("oow_valid", 32'(rd_valid), 32'h1);
        wr(8'hEF, 8'hFF);
        chk("oow_wr",    32'(out_gpio), 32'hA500);
        wr(8'hF1, 8'h77);
        wr(8'hF0, 8'h11);
        cyc(1'b0, 1'b1, 1'b1, 8'hF0, 8'h22);
        chk("rdw_old",   32'(rd_data),  32'h11);
        chk("rdw_new",   32'(out_gpio), 32'hA522);

        // reset mid-access with state loaded, then no spurious capture
        wr(8'hF2, 8'hFF);
        gin = '0;
        idle(4);
        gin = 16'h00FF;
        idle(3);
        chk("pnd_ff_irq", 32'(irq), 32'h1);
        rd(8'hF3);
        chk("pnd_ff",    32'(rd_data), 32'hFF);
        wr(8'hF0, 8'h3C);
        chk("out_3c",    32'(out_gpio), 32'hA53C);
        gin = '1;
        cyc(1'b1, 1'b1, 1'b1, 8'hF0, 8'h55);
        chk("rst2_out",  32'(out_gpio), 32'h0);
        chk("rst2_irq",  32'(irq),      32'h0);
        chk("rst2_rv",   32'(rd_valid), 32'h0);
        chk("rst2_rd",   32'(rd_data),  32'h0);
        idle(5);
        chk("held_hi",   32'(irq), 32'h0);
        wr(8'hF2, 8'hFF);
        idle(4);
        chk("en_no_edge", 32'(irq), 32'h0);
        gin = '0;
        idle(4);
        gin = '1;
        idle(3);
        chk("new_edge",  32'(irq), 32'h1);
        rd(8'hF3);
        chk("new_pnd",   32'(rd_data), 32'hFF);

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            logic          r;
            logic [AW-1:0] a;
            r = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 7) != 0)
                a = AW'(BASE + $urandom_range(0, 4 * NP - 1));
            else
                a = AW'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0)
                gin = gin ^ NW'($urandom);
            cyc(r, 1'($urandom), 1'($urandom), a, DW'($urandom));
        end

        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
